// File: rtl/mc_defs.sv
// ---------------------------------------------------------------------------
// mc_defs -- shared definitions for the multicycle MIPS control unit.
// Contents: FSM state codes, primary opcode constants (also used by the
// single-cycle decoder), opcode class codes, and the ALUOp / ALUSrcB /
// PCSource encodings. No ports; imported with "import mc_defs::*;".
// ---------------------------------------------------------------------------
package mc_defs;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_JUMP   = 4'd10,
        S_JAL    = 4'd11
    } state_t;

    // Primary opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Opcode classes; CLS_NONE (0) doubles as "illegal" and the reset value.
    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_LW     = 4'd1,
        CLS_SW     = 4'd2,
        CLS_RTYPE  = 4'd3,
        CLS_BEQ    = 4'd4,
        CLS_BNE    = 4'd5,
        CLS_J      = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_IADD   = 4'd8,
        CLS_ILOGIC = 4'd9,
        CLS_ISLT   = 4'd10
    } opclass_t;

    // ALUOp classes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALUOp for an immediate-class instruction; 00 for every other class.
    function automatic logic [1:0] imm_aluop(input opclass_t cls);
        case (cls)
            CLS_ILOGIC: imm_aluop = ALUOP_FUNCT;
            CLS_ISLT:   imm_aluop = ALUOP_SLT;
            default:    imm_aluop = ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_opclass.sv
// ---------------------------------------------------------------------------
// mc_opclass -- combinational decode of the 6-bit primary opcode into an
// instruction class used by the multicycle control FSM.
// Ports:
//   opcode  in  6  instruction[31:26]
//   opclass out 4  class code (CLS_NONE for unsupported opcodes)
// ---------------------------------------------------------------------------
module mc_opclass
    import mc_defs::*;
(
    input  logic [5:0] opcode,
    output opclass_t   opclass
);

    // Opcode to class lookup
    always_comb begin
        case (opcode)
            OP_LW:                       opclass = CLS_LW;
            OP_SW:                       opclass = CLS_SW;
            OP_RTYPE:                    opclass = CLS_RTYPE;
            OP_BEQ:                      opclass = CLS_BEQ;
            OP_BNE:                      opclass = CLS_BNE;
            OP_J:                        opclass = CLS_J;
            OP_JAL:                      opclass = CLS_JAL;
            OP_ADDI, OP_LUI:             opclass = CLS_IADD;
            OP_ANDI, OP_ORI, OP_XORI:    opclass = CLS_ILOGIC;
            OP_SLTI, OP_SLTIU:           opclass = CLS_ISLT;
            default:                     opclass = CLS_NONE;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// ---------------------------------------------------------------------------
// mc_control -- multicycle MIPS control FSM (Moore outputs).
// Optional feature: define MEM_HANDSHAKE_EN to make FETCH/MEMRD/MEMWR wait for
// mem_ready, with a WAIT_MAX-cycle timeout that sets err and returns to FETCH.
// Without it mem_ready is ignored and no wait counter exists.
// Ports:
//   clk, reset (async, active-high), opcode[5:0], mem_ready
//   PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemToReg RegDst
//   RegWrite ALUSrcA Link BranchNe           -- 1-bit controls
//   ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0]     -- encoded selects
//   state[3:0] current state, err sticky fault flag
// ---------------------------------------------------------------------------
module mc_control
    import mc_defs::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       Link,
    output logic       BranchNe,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       err
);

    state_t   state_r;
    opclass_t class_r;
    opclass_t opclass_s;
    logic     err_r;
    logic     mem_state_s;
    logic     mem_stall_s;
    logic     mem_timeout_s;
    logic     fetch_go_s;

    mc_opclass u_opclass (
        .opcode  (opcode),
        .opclass (opclass_s)
    );

    assign mem_state_s = (state_r == S_FETCH) || (state_r == S_MEMRD) ||
                         (state_r == S_MEMWR);

`ifdef MEM_HANDSHAKE_EN
    localparam int CW = $clog2(WAIT_MAX + 1);
    logic [CW-1:0] wait_cnt_r;

    assign mem_stall_s   = mem_state_s && !mem_ready;
    assign mem_timeout_s = mem_stall_s && (wait_cnt_r == CW'(WAIT_MAX - 1));
    assign fetch_go_s    = mem_ready;

    // Consecutive mem_ready-low cycle counter, cleared on progress or timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= '0;
        end else if (mem_stall_s && !mem_timeout_s) begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
        end else begin
            wait_cnt_r <= '0;
        end
    end
`else
    logic unused_cfg;

    assign mem_stall_s   = 1'b0;
    assign mem_timeout_s = 1'b0;
    assign fetch_go_s    = 1'b1;
    assign unused_cfg    = mem_ready ^ mem_state_s ^ (WAIT_MAX == 0);
`endif

    // State, latched opcode class and sticky error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
            class_r <= CLS_NONE;
            err_r   <= 1'b0;
        end else if (mem_timeout_s) begin
            state_r <= S_FETCH;
            err_r   <= 1'b1;
        end else if (mem_stall_s) begin
            state_r <= state_r;
        end else begin
            case (state_r)
                S_FETCH:  state_r <= S_DECODE;
                S_DECODE: begin
                    // Dispatch uses the live opcode; later states use class_r.
                    class_r <= opclass_s;
                    case (opclass_s)
                        CLS_LW, CLS_SW:                 state_r <= S_MEMADR;
                        CLS_RTYPE:                      state_r <= S_REXEC;
                        CLS_BEQ, CLS_BNE:               state_r <= S_BRANCH;
                        CLS_J:                          state_r <= S_JUMP;
                        CLS_JAL:                        state_r <= S_JAL;
                        CLS_IADD, CLS_ILOGIC, CLS_ISLT: state_r <= S_IEXEC;
                        default: begin
                            state_r <= S_FETCH;
                            err_r   <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: state_r <= (class_r == CLS_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  state_r <= S_MEMWB;
                S_REXEC:  state_r <= S_ALUWB;
                S_IEXEC:  state_r <= S_ALUWB;
                default:  state_r <= S_FETCH;
            endcase
        end
    end

    logic       pc_write_s, pc_write_cond_s, iord_s, mem_read_s, mem_write_s;
    logic       ir_write_s, mem_to_reg_s, reg_dst_s, reg_write_s;
    logic       alu_src_a_s, link_s, branch_ne_s;
    logic [1:0] alu_src_b_s, alu_op_s, pc_source_s;

    // Moore output decode from state and latched class
    always_comb begin
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        iord_s          = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        mem_to_reg_s    = 1'b0;
        reg_dst_s       = 1'b0;
        reg_write_s     = 1'b0;
        alu_src_a_s     = 1'b0;
        link_s          = 1'b0;
        branch_ne_s     = 1'b0;
        alu_src_b_s     = SRCB_REG;
        alu_op_s        = ALUOP_ADD;
        pc_source_s     = PCSRC_ALU;
        case (state_r)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                ir_write_s  = fetch_go_s;
                pc_write_s  = fetch_go_s;
                alu_src_b_s = SRCB_FOUR;
            end
            S_DECODE: alu_src_b_s = SRCB_SHIMM;
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                iord_s     = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
            end
            S_MEMWR: begin
                mem_write_s = 1'b1;
                iord_s      = 1'b1;
            end
            S_REXEC: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = (class_r == CLS_RTYPE);
                // Immediate classes keep their ALUOp through writeback.
                alu_op_s    = imm_aluop(class_r);
            end
            S_BRANCH: begin
                alu_src_a_s     = 1'b1;
                alu_op_s        = ALUOP_SUB;
                pc_write_cond_s = 1'b1;
                pc_source_s     = PCSRC_ALUOUT;
                branch_ne_s     = (class_r == CLS_BNE);
            end
            S_IEXEC: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_IMM;
                alu_op_s    = imm_aluop(class_r);
            end
            S_JUMP: begin
                pc_write_s  = 1'b1;
                pc_source_s = PCSRC_JUMP;
            end
            S_JAL: begin
                pc_write_s  = 1'b1;
                pc_source_s = PCSRC_JUMP;
                reg_write_s = 1'b1;
                link_s      = 1'b1;
            end
            default: pc_source_s = PCSRC_ALU;
        endcase
    end

    // Write-enables are forced low while reset is held, independent of clk.
    assign PCWrite     = pc_write_s      & ~reset;
    assign PCWriteCond = pc_write_cond_s & ~reset;
    assign MemWrite    = mem_write_s     & ~reset;
    assign RegWrite    = reg_write_s     & ~reset;
    assign IRWrite     = ir_write_s      & ~reset;
    assign IorD        = iord_s;
    assign MemRead     = mem_read_s;
    assign MemToReg    = mem_to_reg_s;
    assign RegDst      = reg_dst_s;
    assign ALUSrcA     = alu_src_a_s;
    assign Link        = link_s;
    assign BranchNe    = branch_ne_s;
    assign ALUSrcB     = alu_src_b_s;
    assign ALUOp       = alu_op_s;
    assign PCSource    = pc_source_s;
    assign state       = state_r;
    assign err         = err_r;

endmodule

// File: tb/tb_mc_control.sv
// ---------------------------------------------------------------------------
// tb_mc_control -- table-driven bench for mc_control. Each table row gives
// the opcode to drive for one cycle and the expected state and control word
// for that cycle; hand-written sequences cover asynchronous reset and, when
// MEM_HANDSHAKE_EN is defined, memory wait and timeout behaviour.
// ---------------------------------------------------------------------------
module tb_mc_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'b000000;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemToReg, RegDst, RegWrite, ALUSrcA, Link, BranchNe;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic       err;

    mc_control #(.WAIT_MAX(15)) u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .Link(Link), .BranchNe(BranchNe),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .state(state), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, link, bne;
        logic [1:0] asb, aop, psrc;
        logic       err;
    } ctl_t;

    typedef struct {
        logic [5:0] opc;
        logic [3:0] st;
        ctl_t       ctl;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    logic cur_err = 1'b0;

    ctl_t c_fetch, c_decode, c_memadr, c_memrd, c_memwb, c_memwr, c_rexec, c_wb_r;
    ctl_t c_iex_add, c_iex_log, c_iex_slt, c_wb_add, c_wb_log, c_wb_slt;
    ctl_t c_beq, c_bne, c_j, c_jal;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, SLTI = 6'b001010;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, JJ = 6'b000010;
    localparam logic [5:0] JAL = 6'b000011, BAD = 6'b111111;

    function automatic ctl_t dut_ctl();
        ctl_t a;
        a.pcw = PCWrite;   a.pcwc = PCWriteCond; a.iord = IorD;   a.mrd = MemRead;
        a.mwr = MemWrite;  a.irw = IRWrite;      a.m2r = MemToReg; a.rdst = RegDst;
        a.rw = RegWrite;   a.asa = ALUSrcA;      a.link = Link;   a.bne = BranchNe;
        a.asb = ALUSrcB;   a.aop = ALUOp;        a.psrc = PCSource; a.err = err;
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [5:0] opc, input logic [3:0] st, input ctl_t c);
        vec_t v;
        v.opc = opc;
        v.st = st;
        v.ctl = c;
        v.ctl.err = cur_err;
        vecs.push_back(v);
    endtask

    task automatic init_consts();
        c_fetch = '0;  c_fetch.pcw = 1'b1; c_fetch.mrd = 1'b1; c_fetch.irw = 1'b1;
                       c_fetch.asb = 2'b01;
        c_decode = '0; c_decode.asb = 2'b11;
        c_memadr = '0; c_memadr.asa = 1'b1; c_memadr.asb = 2'b10;
        c_memrd = '0;  c_memrd.mrd = 1'b1; c_memrd.iord = 1'b1;
        c_memwb = '0;  c_memwb.rw = 1'b1; c_memwb.m2r = 1'b1;
        c_memwr = '0;  c_memwr.mwr = 1'b1; c_memwr.iord = 1'b1;
        c_rexec = '0;  c_rexec.asa = 1'b1; c_rexec.aop = 2'b10;
        c_wb_r = '0;   c_wb_r.rw = 1'b1; c_wb_r.rdst = 1'b1;
        c_iex_add = '0; c_iex_add.asa = 1'b1; c_iex_add.asb = 2'b10;
        c_iex_log = c_iex_add; c_iex_log.aop = 2'b10;
        c_iex_slt = c_iex_add; c_iex_slt.aop = 2'b11;
        c_wb_add = '0; c_wb_add.rw = 1'b1;
        c_wb_log = c_wb_add; c_wb_log.aop = 2'b10;
        c_wb_slt = c_wb_add; c_wb_slt.aop = 2'b11;
        c_beq = '0;    c_beq.asa = 1'b1; c_beq.aop = 2'b01; c_beq.pcwc = 1'b1;
                       c_beq.psrc = 2'b01;
        c_bne = c_beq; c_bne.bne = 1'b1;
        c_j = '0;      c_j.pcw = 1'b1; c_j.psrc = 2'b10;
        c_jal = c_j;   c_jal.rw = 1'b1; c_jal.link = 1'b1;
    endtask

    task automatic build_table();
        // lw: opcode switched to sw after DECODE must not change the path
        push(LW, 4'd0, c_fetch); push(LW, 4'd1, c_decode); push(SW, 4'd2, c_memadr);
        push(SW, 4'd3, c_memrd); push(SW, 4'd4, c_memwb);
        push(SW, 4'd0, c_fetch); push(SW, 4'd1, c_decode); push(SW, 4'd2, c_memadr);
        push(SW, 4'd5, c_memwr);
        push(RT, 4'd0, c_fetch); push(RT, 4'd1, c_decode); push(RT, 4'd6, c_rexec);
        push(RT, 4'd7, c_wb_r);
        push(ADDI, 4'd0, c_fetch); push(ADDI, 4'd1, c_decode); push(ADDI, 4'd9, c_iex_add);
        push(ADDI, 4'd7, c_wb_add);
        push(ANDI, 4'd0, c_fetch); push(ANDI, 4'd1, c_decode); push(ANDI, 4'd9, c_iex_log);
        push(ANDI, 4'd7, c_wb_log);
        push(SLTI, 4'd0, c_fetch); push(SLTI, 4'd1, c_decode); push(ADDI, 4'd9, c_iex_slt);
        push(ADDI, 4'd7, c_wb_slt);
        push(BEQ, 4'd0, c_fetch); push(BEQ, 4'd1, c_decode); push(BNE, 4'd8, c_beq);
        push(BNE, 4'd0, c_fetch); push(BNE, 4'd1, c_decode); push(BNE, 4'd8, c_bne);
        push(JJ, 4'd0, c_fetch); push(JJ, 4'd1, c_decode); push(JJ, 4'd10, c_j);
        push(JAL, 4'd0, c_fetch); push(JAL, 4'd1, c_decode); push(JAL, 4'd11, c_jal);
        push(BAD, 4'd0, c_fetch); push(BAD, 4'd1, c_decode);
        cur_err = 1'b1;
        push(JJ, 4'd0, c_fetch); push(JJ, 4'd1, c_decode); push(JJ, 4'd10, c_j);
        push(LW, 4'd0, c_fetch); push(LW, 4'd1, c_decode); push(LW, 4'd2, c_memadr);
        push(LW, 4'd3, c_memrd);
    endtask

    initial begin
        init_consts();
        build_table();

        // Reset held: FETCH, no error, all write-enables low
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_we", 32'({PCWrite, PCWriteCond, MemWrite, RegWrite, IRWrite}), 32'd0);
`ifdef MEM_HANDSHAKE_EN
        mem_ready = 1'b1;
`endif
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            opcode = vecs[i].opc;
            #1;
            chk($sformatf("row%0d_state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("row%0d_ctl", i), 32'(dut_ctl()), 32'(vecs[i].ctl));
            if (i < vecs.size() - 1) @(negedge clk);
        end

        // Mid-MEMRD asynchronous reset: effect visible before the next edge
        #2 reset = 1'b1;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_we", 32'({PCWrite, PCWriteCond, MemWrite, RegWrite, IRWrite}), 32'd0);
        chk("async_rst_err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        opcode = JJ;
        #1;
        chk("post_rst_fetch", 32'(state), 32'd0);
        @(negedge clk);
        #1;
        chk("post_rst_decode", 32'(state), 32'd1);
        @(negedge clk);

`ifdef MEM_HANDSHAKE_EN
        // sw with mem_ready low for 3 MEMWR cycles
        @(negedge clk);
        opcode = SW;
        mem_ready = 1'b1;
        while (state != 4'd0 && checks < 1000) @(negedge clk);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k == 3);
            #1;
            chk($sformatf("hs_memwr%0d_state", k), 32'(state), 32'd5);
            chk($sformatf("hs_memwr%0d_we", k), 32'(MemWrite), 32'd1);
            @(negedge clk);
        end
        #1;
        chk("hs_after_state", 32'(state), 32'd0);
        chk("hs_after_err", 32'(err), 32'd0);
        // Same again, but mem_ready stays low for 16 cycles
        repeat (3) @(negedge clk);
        chk("hs_to_memwr", 32'(state), 32'd5);
        mem_ready = 1'b0;
        repeat (16) @(negedge clk);
        #1;
        chk("hs_timeout_err", 32'(err), 32'd1);
        chk("hs_timeout_state", 32'(state), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum consecutive mem_ready-low cycles in any memory state before err is raised.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 opcode  in  6  instruction[31:26], read from the instruction register.
REQ-005 mem_ready  in  1  memory access complete; used only with MEM_HANDSHAKE_EN.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite  out  1 each  standard multicycle PC and memory controls.
REQ-007 MemToReg, RegDst, RegWrite, ALUSrcA, Link, BranchNe  out  1 each  writeback, ALU-A select, JAL link, BNE polarity.
REQ-008 ALUSrcB, ALUOp, PCSource  out  2 each  ALU-B select (00 reg, 01 const 4, 10 sign-ext imm, 11 shifted imm), ALU decoder class, next-PC select (00 ALU, 01 ALUOut, 10 jump target).
REQ-009 state  out  4  current state code; err  out  1  sticky fault flag.

Function
REQ-010 The FSM SHALL use the states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, ALUWB=7, BRANCH=8, IEXEC=9, JUMP=10, JAL=11; all other codes SHALL return to FETCH.
REQ-011 FETCH SHALL assert MemRead, IRWrite, PCWrite, ALUSrcB=01, ALUOp=00, PCSource=00, then go to DECODE.
REQ-012 DECODE SHALL assert ALUSrcB=11, ALUOp=00, then dispatch: lw/sw to MEMADR, 000000 to REXEC, beq/bne to BRANCH, j to JUMP, jal to JAL, addi/andi/ori/xori/slti/sltiu/lui to IEXEC, any other opcode to FETCH with err set.
REQ-013 MEMADR SHALL assert ALUSrcA, ALUSrcB=10, ALUOp=00, then go to MEMRD for lw or MEMWR for sw.
REQ-014 MEMRD SHALL assert MemRead, IorD, then go to MEMWB; MEMWB SHALL assert RegWrite, MemToReg, RegDst=0, then go to FETCH.
REQ-015 MEMWR SHALL assert MemWrite, IorD, then go to FETCH.
REQ-016 REXEC SHALL assert ALUSrcA, ALUSrcB=00, ALUOp=10, then go to ALUWB with RegDst=1.
REQ-017 IEXEC SHALL assert ALUSrcA, ALUSrcB=10, with ALUOp 00 for addi/lui, 10 for andi/ori/xori, 11 for slti/sltiu, then go to ALUWB with RegDst=0; ALUOp SHALL be held through ALUWB.
REQ-018 ALUWB SHALL assert RegWrite, MemToReg=0, then go to FETCH.
REQ-019 BRANCH SHALL assert ALUSrcA, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01, with BranchNe=1 for bne only, then go to FETCH.
REQ-020 JUMP SHALL assert PCWrite, PCSource=10; JAL SHALL additionally assert RegWrite and Link; both then go to FETCH.
REQ-021 Outputs SHALL be decoded combinationally from state and the latched opcode class (Moore); signals not listed for a state SHALL be 0.
REQ-022 Cycles per instruction SHALL be lw 5, sw 4, R/immediate 4, branch 3, j/jal 3, with zero-wait memory.
REQ-023 The opcode SHALL be latched into an internal class register in DECODE; later changes on the opcode input SHALL NOT alter the instruction in flight.

Reset
REQ-024 While reset is high: state=FETCH, err=0, wait counter=0, latched class=0, and all write-enables (PCWrite, PCWriteCond, MemWrite, RegWrite, IRWrite) SHALL be 0.
REQ-025 Assertion mid-instruction SHALL abort it immediately; the first FETCH SHALL follow the first rising clk edge after reset falls.

Configuration
REQ-026 With MEM_HANDSHAKE_EN defined: FETCH, MEMRD and MEMWR SHALL hold state with outputs stable until mem_ready=1, and PCWrite/IRWrite in FETCH SHALL be gated by mem_ready; after WAIT_MAX low cycles, err SHALL set and the FSM SHALL go to FETCH.
REQ-027 Without MEM_HANDSHAKE_EN: mem_ready SHALL be ignored, every memory state SHALL last one cycle, and no wait counter SHALL be synthesized.

Structure
REQ-028 The state codes, opcode constants (shared with the single-cycle decoder) and ALUOp/ALUSrcB/PCSource encodings SHALL live in a shared package/include, mc_defs.
REQ-029 Next-state and output decode SHALL be one module; the opcode-class decode SHALL be a sub-module, mc_opclass.

Verification
REQ-030 Reset, then opcode=100011 -> states 0,1,2,3,4,0; RegWrite=1 and MemToReg=1 in MEMWB only.
REQ-031 opcode=000101 -> states 0,1,8,0; PCWriteCond=1, BranchNe=1 and ALUOp=01 in BRANCH.
REQ-032 opcode=000011 -> states 0,1,11,0; PCWrite=1, PCSource=10, RegWrite=1 and Link=1 in JAL.
REQ-033 opcode=111111 -> DECODE then FETCH; err=1 stays set until reset.
REQ-034 MEM_HANDSHAKE_EN, sw with mem_ready low 3 cycles in MEMWR -> MemWrite held 4 cycles, then FETCH, err=0; held low 16 cycles -> err=1.
REQ-035 Reset asserted in MEMRD -> state=0 and all write-enables 0 in the same cycle, without waiting for clk.
